// File: rtl/int_ctrl_wb_pkg.sv
// Shared definitions for the Wishbone interrupt controller: register map,
// IVR field positions and the index-width helper.
package int_ctrl_wb_pkg;

    localparam int ADDR_MER = 0;
    localparam int ADDR_IER = 1;
    localparam int ADDR_MODE = 2;
    localparam int ADDR_IPR = 3;
    localparam int ADDR_IVR = 4;
    localparam int ADDR_RAW = 5;

    localparam int IVR_VALID_BIT = 31;

    // Number of bits needed to index n sources, never less than one.
    function automatic int log2_min1(input int n);
        int r;
        r = 1;
        while ((32'sd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/int_ctrl_wb_if.sv
// Wishbone slave bus bundle for the interrupt controller.
interface int_ctrl_wb_if #(
    parameter int Aw   = 3,
    parameter int SELw = 4,
    parameter int TAGw = 3,
    parameter int Dw   = 32
);
    logic [Dw-1:0]   sa_dat_i;
    logic [SELw-1:0] sa_sel_i;
    logic [Aw-1:0]   sa_addr_i;
    logic [TAGw-1:0] sa_tag_i;
    logic            sa_stb_i;
    logic            sa_cyc_i;
    logic            sa_we_i;
    logic [Dw-1:0]   sa_dat_o;
    logic            sa_ack_o;
    logic            sa_err_o;
    logic            sa_rty_o;

    modport master (
        output sa_dat_i, sa_sel_i, sa_addr_i, sa_tag_i, sa_stb_i, sa_cyc_i, sa_we_i,
        input  sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
    );

    modport slave (
        input  sa_dat_i, sa_sel_i, sa_addr_i, sa_tag_i, sa_stb_i, sa_cyc_i, sa_we_i,
        output sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
    );
endinterface

// File: rtl/int_prio_enc.sv
// Combinational fixed-priority encoder: the lowest-numbered set request wins.
module int_prio_enc #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    output logic [IDW-1:0] idx,
    output logic           valid
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            idx   = req[i] ? IDW'(i) : idx;
            valid = valid | req[i];
        end
    end

endmodule

// File: rtl/int_ctrl_wb.sv
// Wishbone interrupt controller: per-source enable, level/edge mode, pending
// latch and a claim-on-read fixed-priority vector register.
module int_ctrl_wb
    import int_ctrl_wb_pkg::*;
#(
    parameter int INT_NUM = 8,
    parameter int Aw      = 3,
    parameter int SELw    = 4,
    parameter int TAGw    = 3,
    parameter int Dw      = 32
) (
    input  logic               clk,
    input  logic               reset,
    int_ctrl_wb_if.slave       sa,
    input  logic [INT_NUM-1:0] int_i,
    output logic               int_o
);

    localparam int IDw = log2_min1(INT_NUM);

    logic [INT_NUM-1:0] int_q_r, pend_r, ier_r, mode_r;
    logic [INT_NUM-1:0] pend_nxt_s, edge_s, w1c_s, claim_s, act_s;
    logic               mer_r, ack_r, int_o_r;
    logic [Dw-1:0]      rdata_r, rdata_nxt_s;
    logic               acc_s, wr_s, rd_s, vec_vld_s;
    logic [IDw-1:0]     vec_idx_s;

    logic [SELw-1:0]       sel_unused_s;
    logic [TAGw-1:0]       tag_unused_s;
    logic                  cyc_unused_s;
    logic [Dw-INT_NUM-1:0] dat_unused_s;

    assign sel_unused_s = sa.sa_sel_i;
    assign tag_unused_s = sa.sa_tag_i;
    assign cyc_unused_s = sa.sa_cyc_i;
    assign dat_unused_s = sa.sa_dat_i[Dw-1:INT_NUM];

    // A strobe only takes effect on the cycle before its ack, so a held strobe acts once.
    assign acc_s  = sa.sa_stb_i & ~ack_r;
    assign wr_s   = acc_s & sa.sa_we_i;
    assign rd_s   = acc_s & ~sa.sa_we_i;
    assign act_s  = pend_r & ier_r;
    assign edge_s = int_i & ~int_q_r;

    int_prio_enc #(.N(INT_NUM), .IDW(IDw)) u_prio_enc (
        .req   (act_s),
        .idx   (vec_idx_s),
        .valid (vec_vld_s)
    );

    // Read mux, clear masks and next pending state; a new edge beats any clear.
    always_comb begin
        rdata_nxt_s = '0;
        w1c_s       = '0;
        claim_s     = '0;
        case (sa.sa_addr_i)
            Aw'(ADDR_MER):  rdata_nxt_s = Dw'(mer_r);
            Aw'(ADDR_IER):  rdata_nxt_s = Dw'(ier_r);
            Aw'(ADDR_MODE): rdata_nxt_s = Dw'(mode_r);
            Aw'(ADDR_IPR):  rdata_nxt_s = Dw'(pend_r);
            Aw'(ADDR_IVR): begin
                rdata_nxt_s[IVR_VALID_BIT] = vec_vld_s;
                rdata_nxt_s[IDw-1:0]       = vec_idx_s;
            end
            Aw'(ADDR_RAW):  rdata_nxt_s = Dw'(int_q_r);
            default:        rdata_nxt_s = '0;
        endcase
        if (wr_s && (sa.sa_addr_i == Aw'(ADDR_IPR))) begin
            w1c_s = sa.sa_dat_i[INT_NUM-1:0];
        end else begin
            w1c_s = '0;
        end
        if (rd_s && (sa.sa_addr_i == Aw'(ADDR_IVR)) && vec_vld_s) begin
            claim_s = INT_NUM'(1) << vec_idx_s;
        end else begin
            claim_s = '0;
        end
        pend_nxt_s = (mode_r & ((pend_r & ~(w1c_s | claim_s)) | edge_s))
                   | (~mode_r & int_q_r);
    end

    // Bus side: ack, read-data capture and configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_r   <= 1'b0;
            rdata_r <= '0;
            mer_r   <= 1'b0;
            ier_r   <= '0;
            mode_r  <= '0;
        end else begin
            ack_r <= sa.sa_stb_i & ~ack_r;
            if (rd_s) begin
                rdata_r <= rdata_nxt_s;
            end
            if (wr_s) begin
                case (sa.sa_addr_i)
                    Aw'(ADDR_MER):  mer_r  <= sa.sa_dat_i[0];
                    Aw'(ADDR_IER):  ier_r  <= sa.sa_dat_i[INT_NUM-1:0];
                    Aw'(ADDR_MODE): mode_r <= sa.sa_dat_i[INT_NUM-1:0];
                    default:        ;
                endcase
            end
        end
    end

    // Interrupt path: input sample, pending latch, registered processor line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_q_r <= '0;
            pend_r  <= '0;
            int_o_r <= 1'b0;
        end else begin
            int_q_r <= int_i;
            pend_r  <= pend_nxt_s;
            int_o_r <= mer_r & (|act_s);
        end
    end

    assign sa.sa_ack_o = ack_r;
    assign sa.sa_dat_o = rdata_r;
    assign sa.sa_err_o = 1'b0;
    assign sa.sa_rty_o = 1'b0;
    assign int_o       = int_o_r;

endmodule

// File: tb/tb_int_ctrl_wb.sv
// Self-checking bench for int_ctrl_wb: directed scenarios plus random traffic
// checked every cycle against a per-source behavioural model.
module tb_int_ctrl_wb;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] int_i;
    logic       int_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit        m_mer, m_into, m_ack;
    bit [7:0]  m_ier, m_mode, m_pend, m_intq;
    bit [31:0] m_rdata;

    int_ctrl_wb_if wb ();

    int_ctrl_wb #(.INT_NUM(8)) dut (
        .clk   (clk),
        .reset (reset),
        .sa    (wb),
        .int_i (int_i),
        .int_o (int_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mer = 1'b0; m_into = 1'b0; m_ack = 1'b0;
        m_ier = 8'h00; m_mode = 8'h00; m_pend = 8'h00; m_intq = 8'h00;
        m_rdata = 32'h0;
    endtask

    // Applies the register-map rules to the inputs seen at this clock edge.
    task automatic model_step();
        bit        acc, we, cval;
        bit [2:0]  a;
        bit [31:0] d, rv;
        bit [7:0]  np;
        int        cidx;
        acc = wb.sa_stb_i && !m_ack;
        we  = wb.sa_we_i;
        a   = wb.sa_addr_i;
        d   = wb.sa_dat_i;
        cval = 1'b0;
        cidx = 0;
        for (int i = 7; i >= 0; i--) begin
            if (m_pend[i] && m_ier[i]) begin
                cval = 1'b1;
                cidx = i;
            end
        end
        case (a)
            3'd0:    rv = {31'h0, m_mer};
            3'd1:    rv = {24'h0, m_ier};
            3'd2:    rv = {24'h0, m_mode};
            3'd3:    rv = {24'h0, m_pend};
            3'd4:    rv = cval ? (32'h8000_0000 | 32'(cidx)) : 32'h0;
            3'd5:    rv = {24'h0, m_intq};
            default: rv = 32'h0;
        endcase
        for (int i = 0; i < 8; i++) begin
            if (m_mode[i]) begin
                np[i] = m_pend[i];
                if (acc && we && a == 3'd3 && d[i]) np[i] = 1'b0;
                if (acc && !we && a == 3'd4 && cval && cidx == i) np[i] = 1'b0;
                if (int_i[i] && !m_intq[i]) np[i] = 1'b1;
            end else begin
                np[i] = m_intq[i];
            end
        end
        m_into = m_mer && ((m_pend & m_ier) != 8'h00);
        if (acc && !we) m_rdata = rv;
        if (acc && we) begin
            case (a)
                3'd0:    m_mer  = d[0];
                3'd1:    m_ier  = d[7:0];
                3'd2:    m_mode = d[7:0];
                default: ;
            endcase
        end
        m_pend = np;
        m_intq = int_i;
        m_ack  = acc;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("ack", {31'h0, wb.sa_ack_o}, {31'h0, m_ack});
        chk("int_o", {31'h0, int_o}, {31'h0, m_into});
        chk("dat_o", wb.sa_dat_o, m_rdata);
        chk("err", {31'h0, wb.sa_err_o}, 32'h0);
        chk("rty", {31'h0, wb.sa_rty_o}, 32'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wb.sa_stb_i = 1'b1; wb.sa_we_i = 1'b1; wb.sa_addr_i = a; wb.sa_dat_i = d;
        cycle();
        wb.sa_stb_i = 1'b0; wb.sa_we_i = 1'b0;
        cycle();
    endtask

    task automatic rd_exp(input logic [2:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic        ak;
        wb.sa_stb_i = 1'b1; wb.sa_we_i = 1'b0; wb.sa_addr_i = a;
        cycle();
        d  = wb.sa_dat_o;
        ak = wb.sa_ack_o;
        wb.sa_stb_i = 1'b0;
        cycle();
        chk({tag, "_ack"}, {31'h0, ak}, 32'h1);
        chk(tag, d, exp);
    endtask

    initial begin
        int          acks;
        logic [31:0] hs_d;

        reset = 1'b1;
        int_i = 8'h00;
        wb.sa_dat_i = 32'h0; wb.sa_sel_i = 4'hF; wb.sa_addr_i = 3'd0;
        wb.sa_tag_i = 3'd0;  wb.sa_stb_i = 1'b0; wb.sa_cyc_i = 1'b1; wb.sa_we_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_int_o", {31'h0, int_o}, 32'h0);
        chk("rst_ack", {31'h0, wb.sa_ack_o}, 32'h0);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) rd_exp(3'(a), 32'h0, "rst_reg");

        // Reset in the middle of activity
        wr(3'd0, 32'h1);
        wr(3'd1, 32'hFF);
        int_i = 8'h04; cycle();
        int_i = 8'h00; cycle();
        cycle();
        chk("pre_rst_int_o", {31'h0, int_o}, 32'h1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("midrst_int_o", {31'h0, int_o}, 32'h0);
        chk("midrst_ack", {31'h0, wb.sa_ack_o}, 32'h0);
        #1 reset = 1'b0;
        for (int a = 0; a < 6; a++) rd_exp(3'(a), 32'h0, "midrst_reg");

        // Edge latch and claim order
        wr(3'd2, 32'hFF); wr(3'd1, 32'h0C); wr(3'd0, 32'h1);
        int_i = 8'h08; cycle();
        chk("edge_int_o_1cyc", {31'h0, int_o}, 32'h0);
        int_i = 8'h04; cycle();
        chk("edge_int_o_2cyc", {31'h0, int_o}, 32'h1);
        int_i = 8'h00; cycle();
        rd_exp(3'd4, 32'h8000_0002, "ivr_first");
        rd_exp(3'd4, 32'h8000_0003, "ivr_second");
        chk("edge_int_o_drop", {31'h0, int_o}, 32'h0);
        rd_exp(3'd4, 32'h0, "ivr_empty");

        // Level tracking: reads do not claim
        wr(3'd2, 32'h0); wr(3'd1, 32'h1);
        int_i = 8'h01; cycle(); cycle(); cycle();
        rd_exp(3'd4, 32'h8000_0000, "lvl_ivr_a");
        rd_exp(3'd4, 32'h8000_0000, "lvl_ivr_b");
        rd_exp(3'd4, 32'h8000_0000, "lvl_ivr_c");
        int_i = 8'h00; cycle(); cycle(); cycle();
        chk("lvl_int_o_low", {31'h0, int_o}, 32'h0);
        rd_exp(3'd3, 32'h0, "lvl_ipr_low");

        // W1C in the same cycle as a new edge on the same source
        wr(3'd2, 32'h20); wr(3'd1, 32'h0);
        int_i = 8'h20; cycle();
        int_i = 8'h00; cycle();
        wb.sa_stb_i = 1'b1; wb.sa_we_i = 1'b1; wb.sa_addr_i = 3'd3; wb.sa_dat_i = 32'h20;
        int_i = 8'h20; cycle();
        wb.sa_stb_i = 1'b0; wb.sa_we_i = 1'b0; int_i = 8'h00; cycle();
        rd_exp(3'd3, 32'h20, "w1c_vs_edge");
        wr(3'd3, 32'h20);
        rd_exp(3'd3, 32'h0, "w1c_clear");

        // Master enable masking
        wr(3'd0, 32'h0); wr(3'd2, 32'h0); wr(3'd1, 32'h1);
        int_i = 8'h01; cycle(); cycle(); cycle();
        chk("mask_int_o", {31'h0, int_o}, 32'h0);
        rd_exp(3'd3, 32'h01, "mask_ipr");
        wr(3'd0, 32'h1);
        chk("mask_mer_on", {31'h0, int_o}, 32'h1);
        int_i = 8'h00; cycle(); cycle();

        // Strobe held two cycles: one ack, one claim
        wr(3'd2, 32'hFF); wr(3'd1, 32'hFF);
        int_i = 8'h06; cycle();
        int_i = 8'h00; cycle(); cycle();
        acks = 0;
        wb.sa_stb_i = 1'b1; wb.sa_we_i = 1'b0; wb.sa_addr_i = 3'd4;
        cycle(); acks += int'(wb.sa_ack_o); hs_d = wb.sa_dat_o;
        cycle(); acks += int'(wb.sa_ack_o);
        wb.sa_stb_i = 1'b0;
        cycle(); acks += int'(wb.sa_ack_o);
        chk("hs_acks", 32'(acks), 32'h1);
        chk("hs_data", hs_d, 32'h8000_0001);
        rd_exp(3'd4, 32'h8000_0002, "hs_one_claim");
        rd_exp(3'd7, 32'h0, "unmapped7");

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) int_i = 8'($urandom);
            wb.sa_stb_i  = 1'($urandom_range(0, 1));
            wb.sa_we_i   = ($urandom_range(0, 3) == 0);
            wb.sa_addr_i = 3'($urandom_range(0, 7));
            wb.sa_dat_i  = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
